// File: rtl/adc_cmd_formatter.sv
// Formats one ADC sample per frame as the display command "add <ID>,<CH>,<value>"
// followed by three 0xFF terminators, streamed one byte per valid/ready transfer.
module adc_cmd_formatter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OBJ_ID = 1,
    parameter int unsigned CHAN   = 0
) (
    input  logic              RST_clk,
    input  logic              RST_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic              adc_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              frame_busy,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BCD_W = 16;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);
    localparam logic [7:0] ID_CHR = 8'(32'h30 + OBJ_ID);
    localparam logic [7:0] CH_CHR = 8'(32'h30 + CHAN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_HDR,
        S_VAL,
        S_TERM
    } state_t;

    state_t            r_state, w_state_n;
    logic [DATA_W-1:0] r_shift, w_shift_n;
    logic [BCD_W-1:0]  r_bcd, w_bcd_n, w_bcd_adj;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [2:0]        r_idx, w_idx_n;
    logic [1:0]        r_lead, w_lead_n, w_lead;
    logic [7:0]        r_tx_data, w_tx_data_n;
    logic              r_tx_valid, w_tx_valid_n;
    logic              r_adc_ready, w_adc_ready_n;
    logic              r_frame_busy, w_frame_busy_n;
    logic [7:0]        r_drop_cnt, w_drop_cnt_n;
    logic              w_xfer;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    hdr_byte = 8'h61;
            3'd1:    hdr_byte = 8'h64;
            3'd2:    hdr_byte = 8'h64;
            3'd3:    hdr_byte = 8'h20;
            3'd4:    hdr_byte = ID_CHR;
            3'd6:    hdr_byte = CH_CHR;
            default: hdr_byte = 8'h2C;
        endcase
    endfunction

    function automatic logic [7:0] digit_chr(input logic [BCD_W-1:0] bcd, input logic [1:0] sel);
        case (sel)
            2'd3:    digit_chr = {4'h3, bcd[15:12]};
            2'd2:    digit_chr = {4'h3, bcd[11:8]};
            2'd1:    digit_chr = {4'h3, bcd[7:4]};
            default: digit_chr = {4'h3, bcd[3:0]};
        endcase
    endfunction

    assign w_xfer = r_tx_valid && tx_ready;

    // Add-3 correction applied to every BCD digit before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Most significant nonzero digit; the units digit is always sent
    always_comb begin
        if (r_bcd[15:12] != 4'd0)     w_lead = 2'd3;
        else if (r_bcd[11:8] != 4'd0) w_lead = 2'd2;
        else if (r_bcd[7:4] != 4'd0)  w_lead = 2'd1;
        else                          w_lead = 2'd0;
    end

    always_ff @(posedge RST_clk) begin
        if (!RST_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_lead       <= '0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_adc_ready  <= 1'b1;
            r_frame_busy <= 1'b0;
            r_drop_cnt   <= 8'd0;
        end else begin
            r_state      <= w_state_n;
            r_shift      <= w_shift_n;
            r_bcd        <= w_bcd_n;
            r_cnt        <= w_cnt_n;
            r_idx        <= w_idx_n;
            r_lead       <= w_lead_n;
            r_tx_data    <= w_tx_data_n;
            r_tx_valid   <= w_tx_valid_n;
            r_adc_ready  <= w_adc_ready_n;
            r_frame_busy <= w_frame_busy_n;
            r_drop_cnt   <= w_drop_cnt_n;
        end
    end

    // Next byte is loaded on the edge that completes the current transfer
    always_comb begin
        w_state_n    = r_state;
        w_shift_n    = r_shift;
        w_bcd_n      = r_bcd;
        w_cnt_n      = r_cnt;
        w_idx_n      = r_idx;
        w_lead_n     = r_lead;
        w_tx_data_n  = r_tx_data;
        w_tx_valid_n = r_tx_valid;
        w_drop_cnt_n = r_drop_cnt;

        case (r_state)
            S_IDLE: begin
                if (adc_valid && r_adc_ready) begin
                    w_state_n = S_CONVERT;
                    w_shift_n = adc_data;
                    w_bcd_n   = '0;
                    w_cnt_n   = '0;
                end
            end
            S_CONVERT: begin
                if (r_cnt != CNT_DONE) begin
                    w_bcd_n   = (w_bcd_adj << 1) | BCD_W'(r_shift[DATA_W-1]);
                    w_shift_n = r_shift << 1;
                    w_cnt_n   = r_cnt + CNT_W'(1);
                end else begin
                    w_state_n    = S_HDR;
                    w_idx_n      = 3'd0;
                    w_lead_n     = w_lead;
                    w_tx_valid_n = 1'b1;
                    w_tx_data_n  = hdr_byte(3'd0);
                end
            end
            S_HDR: begin
                if (w_xfer) begin
                    if (r_idx == 3'd7) begin
                        w_state_n   = S_VAL;
                        w_idx_n     = {1'b0, r_lead};
                        w_tx_data_n = digit_chr(r_bcd, r_lead);
                    end else begin
                        w_idx_n     = r_idx + 3'd1;
                        w_tx_data_n = hdr_byte(r_idx + 3'd1);
                    end
                end
            end
            S_VAL: begin
                if (w_xfer) begin
                    if (r_idx == 3'd0) begin
                        w_state_n   = S_TERM;
                        w_tx_data_n = 8'hFF;
                    end else begin
                        w_idx_n     = r_idx - 3'd1;
                        w_tx_data_n = digit_chr(r_bcd, 2'(r_idx - 3'd1));
                    end
                end
            end
            S_TERM: begin
                if (w_xfer) begin
                    if (r_idx == 3'd2) begin
                        w_state_n    = S_IDLE;
                        w_tx_valid_n = 1'b0;
                        w_tx_data_n  = 8'h00;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_n    = S_IDLE;
                w_tx_valid_n = 1'b0;
            end
        endcase

        w_adc_ready_n  = (w_state_n == S_IDLE);
        w_frame_busy_n = (w_state_n != S_IDLE);

        if (adc_valid && !r_adc_ready && (r_drop_cnt != 8'hFF)) begin
            w_drop_cnt_n = r_drop_cnt + 8'd1;
        end
    end

    assign adc_ready  = r_adc_ready;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign frame_busy = r_frame_busy;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: doc/adc_cmd_formatter.md
Name: adc_cmd_formatter

Overview:
- Upstream stage of the UART transmitter; replaces the fixed-string message sequencer with live data.
- Accepts one ADC sample per frame, converts it to unsigned decimal ASCII, and emits a display command frame "add <ID>,<CH>,<value>" followed by 0xFF 0xFF 0xFF.
- Sends the frame as a byte stream over a valid/ready handshake, one byte per transmitter slot.

Parameters:
- DATA_W, 8, ADC sample width; legal range 1..12, so the value has at most 4 decimal digits.
- OBJ_ID, 1, waveform object id; legal range 0..9, emitted as one ASCII digit.
- CHAN, 0, waveform channel; legal range 0..9, emitted as one ASCII digit.

Ports:
- RST_clk  in  1  system clock; all logic on the rising edge.
- RST_n  in  1  reset, synchronous, active-low.
- adc_data  in  DATA_W  unsigned ADC sample.
- adc_valid  in  1  sample present.
- adc_ready  out  1  block idle and accepting a sample.
- tx_data  out  8  byte to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte (driven from the inverse of the transmitter busy flag).
- frame_busy  out  1  a frame is being converted or emitted.
- drop_cnt  out  8  count of samples offered while busy; saturates at 255.

Behaviour:
- Reset (RST_n=0 at a rising edge):
  - FSM goes to IDLE; tx_valid=0, tx_data=0x00, frame_busy=0, adc_ready=1, drop_cnt=0.
  - Reset mid-frame aborts the frame. No remaining bytes are sent after reset releases.
- Transfers:
  - Sample accept: adc_valid && adc_ready at a rising edge.
  - Byte transfer: tx_valid && tx_ready at a rising edge.
- FSM states: IDLE, CONVERT, HDR, VAL, TERM.
- IDLE:
  - adc_ready=1, frame_busy=0.
  - On accept: latch adc_data, go to CONVERT, adc_ready=0.
- CONVERT:
  - Sequential shift-add-3 binary-to-BCD over exactly DATA_W cycles into 4 BCD digits d3..d0.
  - Then go to HDR with tx_valid=1 and tx_data="a".
  - Latency: sample accepted at edge N gives first tx_valid=1 after edge N+DATA_W+1.
- HDR: emits 8 bytes in order: "a" "d" "d" " " (0x30+OBJ_ID) "," (0x30+CHAN) ",".
- VAL:
  - Suppress leading zeros: start at the most significant nonzero digit; d0 is always emitted.
  - Each digit is emitted as 0x30+digit.
- TERM: emits 0xFF three times, then returns to IDLE.
- Frame length: 12 + (number of significant digits - 1) bytes; range 12..15.
- Byte pointer advances only on a transfer.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on reset.
  - The next byte is presented on the edge that completes the transfer, so back-to-back transfers are possible every cycle.
- After the last 0xFF transfers: tx_valid=0 and adc_ready=1 on the same edge.
  - A sample arriving that cycle is accepted on the following edge; a new frame never overlaps the previous one.
- frame_busy=1 in every state except IDLE.
- drop_cnt:
  - Increments on each edge with adc_valid=1 and adc_ready=0.
  - Holds at 255. Dropped samples are discarded and not queued.
- The held sample register cannot change during a frame; adc_data changes while busy have no effect.

Test Plan:
- DATA_W=8, adc_data=200, tx_ready=1 constant -> tx_valid rises 9 cycles after accept; bytes 61 64 64 20 31 2C 30 2C 32 30 30 FF FF FF (14 bytes, one per cycle); then adc_ready=1.
- adc_data=0 -> 61 64 64 20 31 2C 30 2C 30 FF FF FF (12 bytes, single "0" digit); adc_data=7 -> digit byte 0x37 only.
- DATA_W=12, adc_data=4095 -> value bytes 34 30 39 35; frame length 15; first tx_valid 13 cycles after accept.
- tx_ready toggled 1-in-16 cycles (UART-rate back-pressure) -> tx_data stable while stalled; exact 14-byte sequence for 200; no byte duplicated or skipped.
- adc_valid held high for 300 cycles during a long stalled frame -> drop_cnt saturates at 255; exactly one frame emitted per accepted sample.
- RST_n pulsed low for one edge after the 5th byte transfers -> next edge tx_valid=0, drop_cnt=0, adc_ready=1; the next accepted sample emits a complete frame starting with 0x61.
